// File: rtl/fp_cmp_arb_ctrl.sv
// Two-requester round-robin front end around a shared FP compare datapath.
// Adds FMIN/FMAX selection and keeps a sticky fflags accumulator.
module fp_cmp_arb_ctrl #(
  parameter logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [5:0]   req_op,
  input  logic [129:0] req_data1,
  input  logic [129:0] req_data2,
  input  logic [19:0]  req_class1,
  input  logic [19:0]  req_class2,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [63:0]  resp_result,
  output logic [4:0]   resp_flags,
  output logic [4:0]   fflags_acc,
  input  logic         fflags_clr,
  output logic         busy
);

  // state  | meaning
  // IDLE   | arbitrating, req_ready may be asserted
  // EXEC   | comparator evaluates latched operands
  // RESP   | response held until resp_ready
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t       state_q, state_d;
  logic         rr_ptr_q;
  logic         id_q;
  logic [2:0]   op_q;
  logic [64:0]  d1_q, d2_q;
  logic [9:0]   c1_q, c2_q;
  logic         resp_valid_q, resp_id_q;
  logic [63:0]  resp_result_q;
  logic [4:0]   resp_flags_q;
  logic [4:0]   fflags_acc_q, fflags_acc_d;

  logic         grant, gnt_id;
  logic [63:0]  res_d;
  logic [4:0]   flags_d;

  // datapath intermediates
  logic [1:0]   cmp_rm;
  logic         nan1, nan2, any_nan, any_snan, both_zero, eq, lt;
  logic         cmp_bit, cmp_nv, is_max;
  logic [63:0]  sel;
  logic         unused_cls;

  assign unused_cls = ^{c1_q[7:5], c1_q[2:0], c2_q[7:5], c2_q[2:0]};

  assign grant  = |req_ready;
  assign gnt_id = req_ready[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= 1'b0;
      id_q          <= 1'b0;
      op_q          <= '0;
      d1_q          <= '0;
      d2_q          <= '0;
      c1_q          <= '0;
      c2_q          <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      fflags_acc_q  <= '0;
    end else begin
      state_q      <= state_d;
      fflags_acc_q <= fflags_acc_d;
      if (grant) begin
        rr_ptr_q <= ~gnt_id;
        id_q     <= gnt_id;
        op_q     <= gnt_id ? req_op[5:3]        : req_op[2:0];
        d1_q     <= gnt_id ? req_data1[129:65]  : req_data1[64:0];
        d2_q     <= gnt_id ? req_data2[129:65]  : req_data2[64:0];
        c1_q     <= gnt_id ? req_class1[19:10]  : req_class1[9:0];
        c2_q     <= gnt_id ? req_class2[19:10]  : req_class2[9:0];
      end
      if (state_q == S_EXEC) begin
        resp_valid_q  <= 1'b1;
        resp_id_q     <= id_q;
        resp_result_q <= res_d;
        resp_flags_q  <= flags_d;
      end else if (state_q == S_RESP && resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    busy      = (state_q != S_IDLE);
    if (state_q == S_IDLE) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = rr_ptr_q ? 2'b10 : 2'b01;
        default: req_ready = 2'b00;
      endcase
    end
  end

  // A clear coinciding with a completing op keeps that op's flags.
  always_comb begin
    fflags_acc_d = fflags_acc_q;
    if (state_q == S_EXEC)
      fflags_acc_d = fflags_clr ? flags_d : (fflags_acc_q | flags_d);
    else if (fflags_clr)
      fflags_acc_d = '0;
  end

  always_comb begin
    cmp_rm    = op_q[2] ? 2'd1 : op_q[1:0];
    nan1      = c1_q[8] | c1_q[9];
    nan2      = c2_q[8] | c2_q[9];
    any_nan   = nan1 | nan2;
    any_snan  = c1_q[8] | c2_q[8];
    both_zero = (c1_q[3] | c1_q[4]) & (c2_q[3] | c2_q[4]);
    eq        = both_zero | ((d1_q[64] == d2_q[64]) && (d1_q[62:0] == d2_q[62:0]));
    if (both_zero)                lt = 1'b0;
    else if (d1_q[64] != d2_q[64]) lt = d1_q[64];
    else if (d1_q[64])            lt = d1_q[62:0] > d2_q[62:0];
    else                          lt = d1_q[62:0] < d2_q[62:0];

    cmp_bit = 1'b0;
    cmp_nv  = 1'b0;
    case (cmp_rm)
      2'd0:    begin cmp_bit = lt | eq; cmp_nv = any_nan;  end
      2'd1:    begin cmp_bit = lt;      cmp_nv = any_nan;  end
      2'd2:    begin cmp_bit = eq;      cmp_nv = any_snan; end
      default: begin cmp_bit = 1'b0;    cmp_nv = 1'b0;     end
    endcase
    if (any_nan) cmp_bit = 1'b0;

    // FMIN/FMAX: signed zeros ordered -0 < +0; otherwise the FLT result picks.
    is_max = op_q[0];
    if (nan1 && nan2)    sel = CANON_NAN;
    else if (nan1)       sel = d2_q[63:0];
    else if (nan2)       sel = d1_q[63:0];
    else if (both_zero)  sel = (d1_q[64] != d2_q[64] && !(d1_q[64] ^ is_max)) ? d2_q[63:0] : d1_q[63:0];
    else                 sel = (lt ^ is_max) ? d1_q[63:0] : d2_q[63:0];

    res_d   = '0;
    flags_d = '0;
    case (op_q)
      3'd0, 3'd1, 3'd2: begin res_d = {63'b0, cmp_bit}; flags_d = {cmp_nv, 4'b0};   end
      3'd4, 3'd5:       begin res_d = sel;              flags_d = {any_snan, 4'b0}; end
      default:          begin res_d = '0;               flags_d = '0;               end
    endcase
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_flags  = resp_flags_q;
  assign fflags_acc  = fflags_acc_q;

endmodule

// File: tb/tb_fp_cmp_arb_ctrl.sv
// Directed bench for fp_cmp_arb_ctrl: arbitration order, latency, compare and
// FMIN/FMAX results, flag accumulation, back-pressure and reset abort.
module tb_fp_cmp_arb_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready;
  logic [5:0]   req_op;
  logic [129:0] req_data1, req_data2;
  logic [19:0]  req_class1, req_class2;
  logic         resp_valid, resp_ready, resp_id;
  logic [63:0]  resp_result;
  logic [4:0]   resp_flags, fflags_acc;
  logic         fflags_clr, busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [64:0] P1   = 65'h0_3FF0000000000000;
  localparam logic [64:0] P2   = 65'h0_4000000000000000;
  localparam logic [64:0] P3   = 65'h0_4008000000000000;
  localparam logic [64:0] N1   = 65'h1_BFF0000000000000;
  localparam logic [64:0] N2   = 65'h1_C000000000000000;
  localparam logic [64:0] PZ   = 65'h0_0000000000000000;
  localparam logic [64:0] NZ   = 65'h1_8000000000000000;
  localparam logic [64:0] QNAN = 65'h0_7FF8000000000000;
  localparam logic [64:0] SNAN = 65'h0_7FF4000000000000;
  localparam logic [9:0]  C_PN = 10'h040, C_NN = 10'h002, C_PZ = 10'h010,
                          C_NZ = 10'h008, C_SN = 10'h100, C_QN = 10'h200;

  fp_cmp_arb_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data1(req_data1), .req_data2(req_data2),
    .req_class1(req_class1), .req_class2(req_class2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .fflags_acc(fflags_acc), .fflags_clr(fflags_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [64:0] d1,
                         input logic [64:0] d2, input logic [9:0] c1, input logic [9:0] c2);
    req_op[i*3 +: 3]      = op;
    req_data1[i*65 +: 65] = d1;
    req_data2[i*65 +: 65] = d2;
    req_class1[i*10 +: 10] = c1;
    req_class2[i*10 +: 10] = c2;
  endtask

  // Starts and ends just after a falling edge.
  task automatic run_op(input int i, input logic [2:0] op, input logic [64:0] d1,
                        input logic [64:0] d2, input logic [9:0] c1, input logic [9:0] c2,
                        input logic [63:0] er, input logic [4:0] ef,
                        input bit consume, input bit clr_exec, input string tag);
    bit got = 0;
    set_req(i, op, d1, d2, c1, c2);
    req_valid[i] = 1'b1;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (req_ready[i]) begin got = 1; break; end
      @(negedge clk); #1;
    end
    chk({tag, "_accept"}, 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    fflags_clr   = clr_exec;
    @(negedge clk);
    chk({tag, "_lat1_valid"}, 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"},  64'(resp_valid), 64'd1);
    chk({tag, "_id"},     64'(resp_id), 64'(i));
    chk({tag, "_result"}, resp_result, er);
    chk({tag, "_flags"},  64'(resp_flags), 64'(ef));
    if (consume) begin
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk({tag, "_idle"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int cnt [2];
    int g;
    bit got;
    rst = 1'b1; req_valid = 2'b00; req_op = '0; req_data1 = '0; req_data2 = '0;
    req_class1 = '0; req_class2 = '0; resp_ready = 1'b1; fflags_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_acc", 64'(fflags_acc), 64'd0);
    chk("rst_result", resp_result, 64'd0);
    chk("rst_flags", 64'(resp_flags), 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Basic compare, then NV from an sNaN on FEQ and its accumulation/clear.
    run_op(0, 3'd1, P1, P2, C_PN, C_PN, 64'd1, 5'b00000, 1, 0, "flt_1_2");
    run_op(1, 3'd2, SNAN, P1, C_SN, C_PN, 64'd0, 5'b10000, 1, 0, "feq_snan");
    chk("acc_after_snan", 64'(fflags_acc), 64'h10);
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    @(negedge clk); #1;
    chk("acc_after_clr", 64'(fflags_acc), 64'd0);

    // Both requesters always valid: strict alternation starting from 0.
    set_req(0, 3'd0, P1, P2, C_PN, C_PN);
    set_req(1, 3'd0, P1, P2, C_PN, C_PN);
    cnt[0] = 4; cnt[1] = 4;
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      got = 0;
      #1;
      for (int w = 0; w < 20; w++) begin
        if (req_ready != 2'b00) begin got = 1; break; end
        @(negedge clk); #1;
      end
      chk($sformatf("rr_grant%0d", k), 64'(req_ready), (k % 2) ? 64'd2 : 64'd1);
      g = req_ready[1] ? 1 : 0;
      @(posedge clk); #1;
      if (got) begin
        cnt[g]--;
        if (cnt[g] == 0) req_valid[g] = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("rr_resp_id%0d", k), 64'(resp_id), 64'(k % 2));
      @(posedge clk); #1;
      @(negedge clk); #1;
    end
    req_valid = 2'b00;

    // Extra compares and FMIN/FMAX corner cases.
    run_op(0, 3'd0, P2, P2, C_PN, C_PN, 64'd1, 5'b00000, 1, 0, "fle_eq");
    run_op(1, 3'd1, P2, P2, C_PN, C_PN, 64'd0, 5'b00000, 1, 0, "flt_eq");
    run_op(0, 3'd1, N2, N1, C_NN, C_NN, 64'd1, 5'b00000, 1, 0, "flt_neg");
    run_op(1, 3'd1, QNAN, P1, C_QN, C_PN, 64'd0, 5'b10000, 1, 0, "flt_qnan");
    run_op(0, 3'd2, NZ, PZ, C_NZ, C_PZ, 64'd1, 5'b00000, 1, 0, "feq_zeros");
    run_op(1, 3'd4, NZ, PZ, C_NZ, C_PZ, 64'h8000000000000000, 5'b00000, 1, 0, "fmin_nz_pz");
    run_op(0, 3'd4, PZ, NZ, C_PZ, C_NZ, 64'h8000000000000000, 5'b00000, 1, 0, "fmin_pz_nz");
    run_op(1, 3'd5, NZ, PZ, C_NZ, C_PZ, 64'h0, 5'b00000, 1, 0, "fmax_nz_pz");
    run_op(0, 3'd5, QNAN, QNAN, C_QN, C_QN, 64'h7FF8000000000000, 5'b00000, 1, 0, "fmax_qq");
    run_op(1, 3'd5, SNAN, P3, C_SN, C_PN, 64'h4008000000000000, 5'b10000, 1, 0, "fmax_snan");
    run_op(0, 3'd4, N1, P2, C_NN, C_PN, 64'hBFF0000000000000, 5'b00000, 1, 0, "fmin_n1_p2");
    run_op(1, 3'd5, N1, P2, C_NN, C_PN, 64'h4000000000000000, 5'b00000, 1, 0, "fmax_n1_p2");
    run_op(0, 3'd4, QNAN, P2, C_QN, C_PN, 64'h4000000000000000, 5'b00000, 1, 0, "fmin_qnan");
    run_op(1, 3'd3, P1, P2, C_PN, C_PN, 64'd0, 5'b00000, 1, 0, "illegal3");
    chk("acc_sticky", 64'(fflags_acc), 64'h10);
    run_op(0, 3'd1, P1, P2, C_PN, C_PN, 64'd1, 5'b00000, 1, 1, "clr_exec_clean");
    chk("acc_clr_exec_clean", 64'(fflags_acc), 64'd0);
    run_op(1, 3'd2, SNAN, P1, C_SN, C_PN, 64'd0, 5'b10000, 1, 1, "clr_exec_nv");
    chk("acc_clr_exec_nv", 64'(fflags_acc), 64'h10);

    // Back-pressure: response held stable, no new accepts.
    resp_ready = 1'b0;
    run_op(0, 3'd1, P1, P2, C_PN, C_PN, 64'd1, 5'b00000, 0, 0, "stall");
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk($sformatf("stall_valid%0d", k), 64'(resp_valid), 64'd1);
      chk($sformatf("stall_result%0d", k), resp_result, 64'd1);
      chk($sformatf("stall_ready%0d", k), 64'(req_ready), 64'd0);
      chk($sformatf("stall_busy%0d", k), 64'(busy), 64'd1);
    end
    req_valid = 2'b00;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_release_busy", 64'(busy), 64'd0);
    chk("stall_release_valid", 64'(resp_valid), 64'd0);
    #1;

    // Reset while in EXEC aborts the op and restores rr_ptr.
    set_req(0, 3'd1, SNAN, P1, C_SN, C_PN);
    req_valid = 2'b01;
    #1;
    chk("abort_accept", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("abort_in_exec", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_acc", 64'(fflags_acc), 64'd0);
    @(negedge clk);
    chk("abort_no_resp", 64'(resp_valid), 64'd0);
    #1;
    req_valid = 2'b11;
    #1;
    chk("abort_rr_ptr", 64'(req_ready), 64'd1);
    req_valid = 2'b00;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
